ic_bvsge_bvand_witness_checker: RTL

Bit-serial checker sitting directly downstream of the bvsge/bvand Skolem-function stage. Per transaction it takes operands `s`, `t` and the candidate witness `x`, and evaluates the constraint `(x & s) >=s t` (two's-complement signed) MSB-first, one bit per cycle. It returns a `sat` verdict over a valid/ready handshake and keeps saturating pass/fail tallies for regression sweeps over the Skolem output.

---
 rtl/ic_bvsge_bvand_witness_checker.sv | 88 ++++++++
 1 files changed

// File: rtl/ic_bvsge_bvand_witness_checker.sv
// ic_bvsge_bvand_witness_checker: bit-serial MSB-first check of (x & s) >=s t
// with valid/ready handshakes and saturating pass/fail tallies.
module ic_bvsge_bvand_witness_checker #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  s,
    input  logic [W-1:0]  t,
    input  logic [W-1:0]  x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sat,
    input  logic          clear,
    output logic [CW-1:0] pass_cnt,
    output logic [CW-1:0] fail_cnt
);
    localparam int IW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {EQ, GT, LT} cmp_t;

    state_t        state, state_nx;
    cmp_t          cmp, cmp_nx;
    logic [W-1:0]  a_sr, b_sr;
    logic [IW-1:0] bit_idx;
    logic          a_bit, b_bit, msb, last, fire_out;

    always_comb begin
        a_bit    = a_sr[W-1];
        b_bit    = b_sr[W-1];
        msb      = bit_idx == IW'(W-1);
        last     = bit_idx == '0;
        in_ready = state == IDLE;
        out_valid = state == DONE;
        fire_out = out_valid && out_ready;
        // The sign bit has inverted weight, so a 0 there means the larger value.
        cmp_nx   = (cmp == EQ && a_bit != b_bit) ? ((a_bit ^ msb) ? GT : LT) : cmp;
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nx = last ? DONE : SHIFT;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            bit_idx <= '0;
            cmp     <= EQ;
            sat     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                a_sr    <= x & s;
                b_sr    <= t;
                bit_idx <= IW'(W-1);
                cmp     <= EQ;
            end else if (state == SHIFT) begin
                a_sr    <= a_sr << 1;
                b_sr    <= b_sr << 1;
                bit_idx <= bit_idx - 1'b1;
                cmp     <= cmp_nx;
                if (last) sat <= cmp_nx != LT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (clear) begin
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else if (fire_out) begin
            if (sat && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
            if (!sat && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        end
    end
endmodule
